pe_sched: RTL
=============

Name: pe_sched

Overview:
- Tile scheduler that shares a bank of NUM_PE processing elements across the tile jobs of one layer.
- On start, it issues tile ids 0..tile_total-1 to idle PEs in round-robin order, one per cycle at most.
- It tracks per-PE busy state from the PEs' done/error pulses and reports layer completion or an error.
- It sits between the layer-level control registers and the PE array: one pe_start/pe_done pair per PE, driving each PE's control front end.

Parameters:
- NUM_PE, 4: number of PEs scheduled; legal range 2..8.
- TILE_W, 16: width of tile count and tile id.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle layer start pulse; ignored unless state is IDLE
- tile_total  in  TILE_W  number of tiles in the layer; sampled on the accepted start
- pe_done_i  in  NUM_PE  per-PE one-cycle tile-complete pulse
- pe_err_i  in  NUM_PE  per-PE one-cycle error pulse
- pe_start  out  NUM_PE  one-hot (or zero) one-cycle dispatch pulse, registered
- pe_tile_id  out  TILE_W  tile id for the PE being started; valid only while pe_start is non-zero, registered
- pe_busy  out  NUM_PE  per-PE busy flags, registered
- tiles_done  out  TILE_W  count of completed tiles in the current layer
- busy  out  1  high in DISPATCH, DRAIN or ERR
- done  out  1  one-cycle layer-complete pulse
- err  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0; state IDLE; internal issue counter 0; round-robin pointer last_grant = NUM_PE-1.
- Reset mid-operation: same as above. Any pe_done_i arriving afterwards finds its PE not busy and is ignored.
- States: IDLE, DISPATCH, DRAIN, DONE, ERR.
- IDLE:
  - Accepted start latches tile_total, clears tiles_done and the issue counter, and clears err.
  - If tile_total==0, go to DONE; otherwise go to DISPATCH.
- DISPATCH:
  - Each cycle, if issued<total and at least one PE is not busy, grant the first idle PE searching from last_grant+1 upward, modulo NUM_PE.
  - On the grant edge: register pe_start one-hot to that PE, pe_tile_id=issued, set that PE's pe_busy bit, update last_grant, increment issued.
  - Latency: start sampled at edge T gives state DISPATCH from T+1. The first pe_start is visible in cycle T+2, to PE0.
  - When issued reaches total, go to DRAIN.
- Completion:
  - pe_done_i[i] with pe_busy[i]=1 clears pe_busy[i] and increments tiles_done on that edge.
  - That PE is eligible for grant at the next decision, so it can receive a new pe_start one cycle after its done pulse was sampled.
  - pe_done_i on a non-busy PE is ignored and not counted.
  - Several pe_done_i bits in the same cycle each count; tiles_done adds popcount(valid dones).
- Simultaneous grant and done on different PEs in the same edge: both take effect. A busy PE is never granted, so grant and done never hit the same PE on the same edge.
- DRAIN: once tiles_done==total and pe_busy==0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE; busy=0 in DONE.
- Error:
  - Any pe_err_i bit in DISPATCH or DRAIN moves to ERR with err=1 from the next cycle.
  - pe_start is not asserted from the error edge onward; busy bits still clear on done.
  - ERR exits to IDLE once pe_busy==0. err stays high until the next accepted start or rst. done is not pulsed.
  - pe_err_i and pe_done_i for the same PE in one cycle: the done counts and the error wins the state transition.
- pe_err_i in IDLE or DONE is ignored.
- Widths: tiles_done and issued are TILE_W bits. tile_total<=2^TILE_W-1, so no wrap.

Test Plan:
- Reset, then start with tile_total=4, NUM_PE=4, each PE returns pe_done_i 5 cycles after its pe_start. Required: pe_start=0001,0010,0100,1000 in cycles T+2..T+5 with ids 0..3; done pulses once; tiles_done=4.
- tile_total=10, PE done latency 3 cycles. Required: ids 0..9 issued in order, round-robin PE0,1,2,3,0,...; no PE started while busy; done after the 10th completion; busy low the cycle after done.
- tile_total=0. Required: done one cycle after the start edge; pe_start never asserted; tiles_done=0.
- pe_err_i[2] in the cycle after tile 5 issues (tile_total=12). Required: no further pe_start; err=1; state returns to IDLE after outstanding dones clear; done never asserted; next start clears err.
- Spurious pe_done_i[3] while PE3 is idle, plus simultaneous dones on PE0 and PE1. Required: the spurious pulse is ignored; tiles_done increments by 2 in one cycle.
- rst asserted mid-DISPATCH with 2 PEs busy. Required: all outputs 0 next cycle; late pe_done_i is ignored; a new start works normally with the first grant to PE0.

Source files
------------

// File: rtl/pe_sched_if.sv
// Handshake bundle between layer control, the tile scheduler and the PE array.
// The slave side is the scheduler; master is whatever drives start and the PE pulses.
interface pe_sched_if #(
  parameter int NUM_PE = 4,
  parameter int TILE_W = 16
);
  logic              start;
  logic [TILE_W-1:0] tile_total;
  logic [NUM_PE-1:0] pe_done_i;
  logic [NUM_PE-1:0] pe_err_i;
  logic [NUM_PE-1:0] pe_start;
  logic [TILE_W-1:0] pe_tile_id;
  logic [NUM_PE-1:0] pe_busy;
  logic [TILE_W-1:0] tiles_done;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, tile_total, pe_done_i, pe_err_i,
    output pe_start, pe_tile_id, pe_busy, tiles_done, busy, done, err
  );

  modport master (
    output start, tile_total, pe_done_i, pe_err_i,
    input  pe_start, pe_tile_id, pe_busy, tiles_done, busy, done, err
  );
endinterface

// File: rtl/pe_sched.sv
// Round-robin tile dispatcher sharing NUM_PE processing elements across the tiles of one layer.
//
// state      | meaning
// S_IDLE     | waiting for start; outputs hold last layer's result
// S_DISPATCH | granting one tile per cycle to the next idle PE
// S_DRAIN    | all tiles issued, waiting for outstanding completions
// S_DONE     | one-cycle layer-complete pulse
// S_ERR      | error seen, no more grants; waits for busy PEs to finish
module pe_sched #(
  parameter int NUM_PE = 4,
  parameter int TILE_W = 16
) (
  input  logic      clk,
  input  logic      rst,
  pe_sched_if.slave bus
);
  localparam int            PW      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [PW-1:0] LAST_PE = PW'(NUM_PE - 1);

  typedef enum logic [2:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [TILE_W-1:0] total_q, total_d;
  logic [TILE_W-1:0] issued_q, issued_d;
  logic [TILE_W-1:0] tiles_done_q, tiles_done_d;
  logic [TILE_W-1:0] tile_id_q, tile_id_d;
  logic [NUM_PE-1:0] pe_start_q, pe_start_d;
  logic [NUM_PE-1:0] pe_busy_q, pe_busy_d;
  logic [PW-1:0]     last_q, last_d;
  logic              err_q, err_d;

  logic              start_acc, err_hit, grant_en, gnt_found;
  logic [PW-1:0]     gnt_idx;
  logic [NUM_PE-1:0] gnt_oh, done_vld;
  logic [TILE_W-1:0] done_cnt;
  logic              busy_c, done_c;

  // First idle PE strictly after the last grant, wrapping modulo NUM_PE.
  always_comb begin
    logic [PW-1:0] p;
    p         = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_PE; k++) begin
      p = PW'((int'(last_q) + k) % NUM_PE);
      if (!gnt_found && !pe_busy_q[p]) begin
        gnt_found = 1'b1;
        gnt_idx   = p;
      end
    end
    gnt_oh = NUM_PE'(1) << gnt_idx;
  end

  always_comb begin
    start_acc = (state_q == S_IDLE) && bus.start;
    err_hit   = ((state_q == S_DISPATCH) || (state_q == S_DRAIN)) && (|bus.pe_err_i);
    grant_en  = (state_q == S_DISPATCH) && !err_hit && (issued_q < total_q) && gnt_found;
    done_vld  = bus.pe_done_i & pe_busy_q;
    done_cnt  = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      done_cnt = done_cnt + TILE_W'(done_vld[i]);
    end

    total_d      = start_acc ? bus.tile_total : total_q;
    issued_d     = start_acc ? '0 : issued_q + TILE_W'(grant_en);
    tiles_done_d = start_acc ? '0 : tiles_done_q + done_cnt;
    err_d        = start_acc ? 1'b0 : (err_q | err_hit);
    last_d       = start_acc ? LAST_PE : (grant_en ? gnt_idx : last_q);
    pe_start_d   = grant_en ? gnt_oh : '0;
    tile_id_d    = grant_en ? issued_q : '0;
    // A busy PE is never granted, so clear and set never target the same bit.
    pe_busy_d    = (pe_busy_q & ~done_vld) | pe_start_d;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.start) state_d = (bus.tile_total == '0) ? S_DONE : S_DISPATCH;
      S_DISPATCH: if (err_hit) state_d = S_ERR;
                  else if (issued_d == total_q) state_d = S_DRAIN;
      S_DRAIN:    if (err_hit) state_d = S_ERR;
                  else if ((tiles_done_q == total_q) && (pe_busy_q == '0)) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      S_ERR:      if (pe_busy_q == '0) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state_q == S_DISPATCH) || (state_q == S_DRAIN) || (state_q == S_ERR);
    done_c = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q      <= '0;
      issued_q     <= '0;
      tiles_done_q <= '0;
      tile_id_q    <= '0;
      pe_start_q   <= '0;
      pe_busy_q    <= '0;
      last_q       <= LAST_PE;
      err_q        <= 1'b0;
    end else begin
      total_q      <= total_d;
      issued_q     <= issued_d;
      tiles_done_q <= tiles_done_d;
      tile_id_q    <= tile_id_d;
      pe_start_q   <= pe_start_d;
      pe_busy_q    <= pe_busy_d;
      last_q       <= last_d;
      err_q        <= err_d;
    end
  end

  assign bus.pe_start   = pe_start_q;
  assign bus.pe_tile_id = tile_id_q;
  assign bus.pe_busy    = pe_busy_q;
  assign bus.tiles_done = tiles_done_q;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.err        = err_q;
endmodule
